bout_controller: RTL
====================

BOUT_CONTROLLER -- requirements
Module: bout_controller

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, meaning the touches needed to win (legal range 1..15).
REQ-002 SHALL have parameter COUNTDOWN_CYCLES, default 1000, meaning the en-garde hold length in cycles (at least 1).
REQ-003 SHALL have parameter PAUSE_CYCLES, default 500, meaning the post-touch halt length in cycles (at least 1).
REQ-004 SHALL use one clock, clk_pixel_in; reset is rst_in, asynchronous and active-high.
REQ-005 SHALL have ports:
- clk_pixel_in  in  1  pixel clock
- rst_in  in  1  async active-high reset
- start_in  in  1  single-cycle pulse that starts a bout
- abort_in  in  1  synchronous return to IDLE
- score_valid_in  in  1  valid strobe for the touch result from action_fsm
- player_scored_in  in  1  player landed a touch
- opponent_scored_in  in  1  opponent landed a touch
- fight_enable_out  out  1  gates ir_in_valid/syncer_in_valid into action_fsm
- state_out  out  3  bout_state_t encoding
- player_score_out  out  4  player touches
- opponent_score_out  out  4  opponent touches
- countdown_out  out  $clog2(max(COUNTDOWN_CYCLES,PAUSE_CYCLES)+1)  remaining timer cycles
- match_over_out  out  1  high in DONE
- winner_out  out  2  00 none, 01 player, 10 opponent, 11 tie

Function
REQ-006 SHALL implement states IDLE, EN_GARDE, FIGHT, HALT, DONE; all outputs are registered.
REQ-007 SHALL, in IDLE, on start_in: clear both scores, load the timer with COUNTDOWN_CYCLES and go to EN_GARDE next cycle.
REQ-008 SHALL decrement the timer by 1 each cycle in EN_GARDE and HALT, and leave the state on the cycle the timer reads 1, so EN_GARDE lasts exactly COUNTDOWN_CYCLES cycles and HALT exactly PAUSE_CYCLES cycles.
REQ-009 SHALL go EN_GARDE to FIGHT; fight_enable_out is 1 exactly while state_out is FIGHT.
REQ-010 SHALL, in FIGHT, on score_valid_in with exactly one scored bit set, increment that score on the next cycle, load PAUSE_CYCLES and go to HALT.
REQ-011 SHALL, in FIGHT, treat score_valid_in with both scored bits clear as no change and stay in FIGHT.
REQ-012 SHALL ignore scored inputs without score_valid_in, and ignore all score events outside FIGHT.
REQ-013 SHALL go to DONE instead of HALT, on the same transition, when an increment makes a score equal WIN_SCORE; scores saturate at WIN_SCORE.
REQ-014 SHALL, in DONE, hold the scores, assert match_over_out and drive winner_out; start_in restarts exactly as REQ-007.
REQ-015 SHALL ignore start_in outside IDLE and DONE.
REQ-016 SHALL, on abort_in in any state, go to IDLE with scores, timer, winner and enable cleared on the next cycle; abort_in wins over a simultaneous start_in or score event.
REQ-017 SHALL hold countdown_out at 0 in IDLE, FIGHT and DONE.

Reset
REQ-018 SHALL, while rst_in is high, immediately force: state IDLE, scores 0, countdown 0, fight_enable_out 0, match_over_out 0, winner_out 00. This holds when reset is asserted mid-bout.

Configuration
REQ-019 SHALL, with DOUBLE_TOUCH_EN defined, treat a valid event with both scored bits set in FIGHT as a double touch: both scores increment. If both reach WIN_SCORE, winner is 11; if one reaches it, that side wins.
REQ-020 SHALL, without DOUBLE_TOUCH_EN, treat a valid event with both bits set as a void touch: no score change, go to HALT.

Structure
REQ-021 SHALL place bout_state_t (3-bit enum), score_t (4-bit) and the winner encoding in the shared types.svh package.
REQ-022 SHALL implement the load/decrement counter as sub-module phase_timer (inputs load and value, outputs count and expire).

Verification
REQ-023 SHALL cover: reset, then start_in, with COUNTDOWN_CYCLES=4 -> EN_GARDE for exactly 4 cycles, then FIGHT with fight_enable_out=1.
REQ-024 SHALL cover: in FIGHT, valid with player_scored=1 -> player_score_out=1 next cycle, HALT for PAUSE_CYCLES, then EN_GARDE.
REQ-025 SHALL cover: with WIN_SCORE=2, two opponent touches -> DONE, opponent_score_out=2, winner_out=10, match_over_out=1.
REQ-026 SHALL cover: valid with both bits set -> both scores +1 with the macro defined; no change and HALT without it.
REQ-027 SHALL cover: abort_in together with start_in and a score event in FIGHT -> IDLE with all outputs 0 next cycle.
REQ-028 SHALL cover: rst_in pulse in HALT -> outputs 0 asynchronously; score events during HALT and EN_GARDE leave the scores unchanged.

Source files
------------

// File: rtl/bout_controller_pkg.sv
// Shared types for the fencing bout controller: state encoding, score width,
// winner encoding and the timer width helper.
package bout_controller_pkg;

   localparam int unsigned SCORE_W = 4;

   typedef logic [SCORE_W-1:0] score_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_EN_GARDE = 3'd1,
      ST_FIGHT    = 3'd2,
      ST_HALT     = 3'd3,
      ST_DONE     = 3'd4
   } bout_state_t;

   typedef enum logic [1:0] {
      WIN_NONE     = 2'b00,
      WIN_PLAYER   = 2'b01,
      WIN_OPPONENT = 2'b10,
      WIN_TIE      = 2'b11
   } winner_t;

   // Bits needed to hold the longer of the two phase lengths.
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/bout_controller_phase_timer.sv
// Loadable down-counter used for the en-garde and halt phases; expire_c_o
// flags the last cycle of a phase (count reads 1).
module phase_timer #(
   parameter int unsigned CNT_W = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] value_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o,
   output logic             expire_c_o
);

   logic [CNT_W-1:0] count_q, count_d;

   // Clear beats load beats decrement; the count never wraps below zero.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = value_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o    = count_q;
   assign expire_c_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/bout_controller.sv
// Fencing bout sequencer: en-garde countdown, fight window, post-touch halt,
// scoring and winner. Define DOUBLE_TOUCH_EN to score simultaneous touches for both.
module bout_controller
   import bout_controller_pkg::*;
#(
   parameter int unsigned WIN_SCORE        = 5,
   parameter int unsigned COUNTDOWN_CYCLES = 1000,
   parameter int unsigned PAUSE_CYCLES     = 500
) (
   input  logic       clk_pixel_in,
   input  logic       rst_in,
   input  logic       start_in,
   input  logic       abort_in,
   input  logic       score_valid_in,
   input  logic       player_scored_in,
   input  logic       opponent_scored_in,
   output logic       fight_enable_out,
   output logic [2:0] state_out,
   output logic [3:0] player_score_out,
   output logic [3:0] opponent_score_out,
   output logic [timer_width(COUNTDOWN_CYCLES, PAUSE_CYCLES)-1:0] countdown_out,
   output logic       match_over_out,
   output logic [1:0] winner_out
);

   localparam int unsigned CNT_W = timer_width(COUNTDOWN_CYCLES, PAUSE_CYCLES);
   localparam score_t           WIN            = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0] COUNTDOWN_LOAD = CNT_W'(COUNTDOWN_CYCLES);
   localparam logic [CNT_W-1:0] PAUSE_LOAD     = CNT_W'(PAUSE_CYCLES);

   bout_state_t state_q, state_d;
   score_t      pscore_q, pscore_d;
   score_t      oscore_q, oscore_d;
   winner_t     winner_q, winner_d;
   logic        fight_en_q;
   logic        match_over_q;

   score_t           p_inc, o_inc;
   logic             tmr_clear, tmr_load, tmr_dec, tmr_expire;
   logic [CNT_W-1:0] tmr_value, tmr_count;

   function automatic score_t sat_inc(input score_t s);
      return (s >= WIN) ? WIN : s + SCORE_W'(1);
   endfunction

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk_i      (clk_pixel_in),
      .rst_i      (rst_in),
      .clear_i    (tmr_clear),
      .load_i     (tmr_load),
      .value_i    (tmr_value),
      .dec_i      (tmr_dec),
      .count_o    (tmr_count),
      .expire_c_o (tmr_expire)
   );

   // Next-state, score and timer control; abort overrides everything else.
   always_comb begin
      state_d   = state_q;
      pscore_d  = pscore_q;
      oscore_d  = oscore_q;
      winner_d  = winner_q;
      tmr_clear = 1'b0;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
      tmr_value = COUNTDOWN_LOAD;
      p_inc     = sat_inc(pscore_q);
      o_inc     = sat_inc(oscore_q);

      if (abort_in) begin
         state_d   = ST_IDLE;
         pscore_d  = '0;
         oscore_d  = '0;
         winner_d  = WIN_NONE;
         tmr_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_in) begin
                  state_d  = ST_EN_GARDE;
                  pscore_d = '0;
                  oscore_d = '0;
                  winner_d = WIN_NONE;
                  tmr_load = 1'b1;
               end
            end
            ST_EN_GARDE: begin
               tmr_dec = 1'b1;
               if (tmr_expire) begin
                  state_d = ST_FIGHT;
               end
            end
            ST_FIGHT: begin
               if (score_valid_in) begin
                  if (player_scored_in && !opponent_scored_in) begin
                     pscore_d = p_inc;
                     if (p_inc == WIN) begin
                        state_d  = ST_DONE;
                        winner_d = WIN_PLAYER;
                     end else begin
                        state_d   = ST_HALT;
                        tmr_load  = 1'b1;
                        tmr_value = PAUSE_LOAD;
                     end
                  end else if (opponent_scored_in && !player_scored_in) begin
                     oscore_d = o_inc;
                     if (o_inc == WIN) begin
                        state_d  = ST_DONE;
                        winner_d = WIN_OPPONENT;
                     end else begin
                        state_d   = ST_HALT;
                        tmr_load  = 1'b1;
                        tmr_value = PAUSE_LOAD;
                     end
                  end else if (player_scored_in && opponent_scored_in) begin
`ifdef DOUBLE_TOUCH_EN
                     pscore_d = p_inc;
                     oscore_d = o_inc;
                     if ((p_inc == WIN) && (o_inc == WIN)) begin
                        state_d  = ST_DONE;
                        winner_d = WIN_TIE;
                     end else if (p_inc == WIN) begin
                        state_d  = ST_DONE;
                        winner_d = WIN_PLAYER;
                     end else if (o_inc == WIN) begin
                        state_d  = ST_DONE;
                        winner_d = WIN_OPPONENT;
                     end else begin
                        state_d   = ST_HALT;
                        tmr_load  = 1'b1;
                        tmr_value = PAUSE_LOAD;
                     end
`else
                     state_d   = ST_HALT;
                     tmr_load  = 1'b1;
                     tmr_value = PAUSE_LOAD;
`endif
                  end
               end
            end
            ST_HALT: begin
               tmr_dec = 1'b1;
               if (tmr_expire) begin
                  state_d  = ST_EN_GARDE;
                  tmr_load = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Flags are registered from the next state so they line up with state_out.
   always_ff @(posedge clk_pixel_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= ST_IDLE;
         pscore_q     <= '0;
         oscore_q     <= '0;
         winner_q     <= WIN_NONE;
         fight_en_q   <= 1'b0;
         match_over_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pscore_q     <= pscore_d;
         oscore_q     <= oscore_d;
         winner_q     <= winner_d;
         fight_en_q   <= (state_d == ST_FIGHT);
         match_over_q <= (state_d == ST_DONE);
      end
   end

   assign state_out          = state_q;
   assign player_score_out   = pscore_q;
   assign opponent_score_out = oscore_q;
   assign countdown_out      = tmr_count;
   assign winner_out         = winner_q;
   assign fight_enable_out   = fight_en_q;
   assign match_over_out     = match_over_q;

endmodule
